// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-atomic round-robin merge of AXI4-Stream sources.
// Define AXIS_PKT_ARBITER_PKTCNT_EN to add per-port packet counters (PKT_COUNT).
module axis_pkt_arbiter #(
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_NUM_SLAVES  = 2,
  parameter int C_IDX_WIDTH   = 3
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_NUM_SLAVES-1:0]                S_AXIS_TVALID,
  input  logic [C_NUM_SLAVES*C_TDATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic [C_NUM_SLAVES*C_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic [C_NUM_SLAVES-1:0]                S_AXIS_TLAST,
  output logic [C_NUM_SLAVES-1:0]                S_AXIS_TREADY,
  output logic                                   M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]               M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]             M_AXIS_TKEEP,
  output logic                                   M_AXIS_TLAST,
  input  logic                                   M_AXIS_TREADY,
  output logic [C_IDX_WIDTH-1:0]                 GRANT_IDX,
`ifdef AXIS_PKT_ARBITER_PKTCNT_EN
  output logic [C_NUM_SLAVES*32-1:0]             PKT_COUNT,
`endif
  output logic                                   BUSY
);

  localparam int KW = C_TDATA_WIDTH / 8;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state_q, state_d;
  logic [C_IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [C_IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic                     busy_q, busy_d;
  logic [C_IDX_WIDTH-1:0]   winner;
  logic                     found;
  logic [2*C_NUM_SLAVES-1:0] req2;
  logic [2*C_NUM_SLAVES-1:0] req_rot;
  logic                     last_xfer;
  int                       sum;

  assign GRANT_IDX = grant_q;
  assign BUSY      = busy_q;

  // Rotate requests so bit 0 is the pointer port, then take the first set bit.
  always_comb begin
    req2    = {S_AXIS_TVALID, S_AXIS_TVALID};
    req_rot = req2 >> ptr_q;
    winner  = '0;
    found   = 1'b0;
    sum     = 0;
    for (int i = 0; i < C_NUM_SLAVES; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + i;
        if (sum >= C_NUM_SLAVES) sum = sum - C_NUM_SLAVES;
        winner = C_IDX_WIDTH'(sum);
      end
    end
  end

  // Combinational pass-through from the granted port while locked.
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    if (state_q == XFER) begin
      for (int i = 0; i < C_NUM_SLAVES; i++) begin
        if (grant_q == C_IDX_WIDTH'(i)) begin
          M_AXIS_TVALID    = S_AXIS_TVALID[i];
          M_AXIS_TDATA     = S_AXIS_TDATA[i*C_TDATA_WIDTH +: C_TDATA_WIDTH];
          M_AXIS_TKEEP     = S_AXIS_TKEEP[i*KW +: KW];
          M_AXIS_TLAST     = S_AXIS_TLAST[i];
          S_AXIS_TREADY[i] = M_AXIS_TREADY;
        end
      end
    end
  end

  assign last_xfer = (state_q == XFER) && M_AXIS_TVALID &&
                     M_AXIS_TREADY && M_AXIS_TLAST;

  // Next state: lock on a winner in IDLE, release after the TLAST beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          busy_d  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (last_xfer) begin
          if (grant_q == C_IDX_WIDTH'(C_NUM_SLAVES - 1)) ptr_d = '0;
          else ptr_d = grant_q + 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AXIS_PKT_ARBITER_PKTCNT_EN
  logic [C_NUM_SLAVES-1:0][31:0] cnt_q, cnt_d;

  assign PKT_COUNT = cnt_q;

  // Count completed packets of the granted port; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (last_xfer) begin
      for (int i = 0; i < C_NUM_SLAVES; i++) begin
        if (grant_q == C_IDX_WIDTH'(i)) cnt_d[i] = cnt_q[i] + 32'd1;
      end
    end
  end

  // Packet counter registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: scoreboard bench for axis_pkt_arbiter (3 ports).
// Sources replay per-port beat queues; the monitor checks every output beat.
module tb_axis_pkt_arbiter;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int K  = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tlast = '0;
  logic [N*W-1:0] s_tdata = '0;
  logic [N*K-1:0] s_tkeep = '0;
  logic [N-1:0]   s_tready;
  logic           m_tvalid, m_tlast, busy;
  logic [W-1:0]   m_tdata;
  logic [K-1:0]   m_tkeep;
  logic           m_tready = 1'b1;
  logic [IW-1:0]  grant_idx;
`ifdef AXIS_PKT_ARBITER_PKTCNT_EN
  logic [N*32-1:0] pkt_count;
`endif

  axis_pkt_arbiter #(
    .C_TDATA_WIDTH(W),
    .C_NUM_SLAVES(N),
    .C_IDX_WIDTH(IW)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TKEEP(s_tkeep),
    .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TKEEP(m_tkeep),
    .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready),
    .GRANT_IDX(grant_idx),
`ifdef AXIS_PKT_ARBITER_PKTCNT_EN
    .PKT_COUNT(pkt_count),
`endif
    .BUSY(busy)
  );

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t src_q[N][$];
  beat_t exp_q[$];
  beat_t mb;
  int tl_cyc[$];
  int fb_cyc[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] hs = '0;
  logic [N-1:0] hold = '0;
  logic [N-1:0] er;
  logic tog_en = 1'b0;
  logic after_last = 1'b0;
  logic in_pkt = 1'b0;

  // Source driver: retire accepted beats, present the next queued beat.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (tog_en) m_tready = ~m_tready;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*W +: W] = src_q[i][0].data;
        s_tkeep[i*K +: K] = src_q[i][0].keep;
        s_tlast[i]        = src_q[i][0].last;
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*W +: W] = '0;
        s_tkeep[i*K +: K] = '0;
        s_tlast[i]        = 1'b0;
      end
    end
    hs = '0;
  end

  // Monitor: routing checks every cycle, scoreboard compare on transfers.
  always @(negedge clk) begin
    hs = s_tvalid & s_tready;
    if (rst_n) begin
      if (after_last) begin
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_last: busy=%b m_tvalid=%b, want 0/0",
                   busy, m_tvalid);
        end
      end
      after_last = 1'b0;
      checks++;
      if (busy) begin
        er = '0;
        if (int'(grant_idx) < N) er[grant_idx] = m_tready;
        if (s_tready !== er) begin
          errors++;
          $display("FAIL ready_route: s_tready=%b, want %b", s_tready, er);
        end
      end else if (s_tready !== '0 || m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: s_tready=%b m_tvalid=%b, want 0/0",
                 s_tready, m_tvalid);
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: data=%h port=%0d, want none",
                   m_tdata, grant_idx);
        end else begin
          mb = exp_q.pop_front();
          if (m_tdata !== mb.data || m_tkeep !== mb.keep ||
              m_tlast !== mb.last || grant_idx !== IW'(mb.port)) begin
            errors++;
            $display("FAIL beat: got p=%0d d=%h k=%h l=%b, want p=%0d d=%h k=%h l=%b",
                     grant_idx, m_tdata, m_tkeep, m_tlast,
                     mb.port, mb.data, mb.keep, mb.last);
          end
        end
        if (!in_pkt) fb_cyc.push_back(cyc);
        in_pkt = !m_tlast;
        if (m_tlast) begin
          tl_cyc.push_back(cyc);
          after_last = 1'b1;
        end
      end
    end else begin
      after_last = 1'b0;
      in_pkt = 1'b0;
    end
  end

  task automatic push_pkt(input int p, input int n, input logic [31:0] base,
                          input logic [3:0] lk, input bit to_exp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.port = 2'(p);
      b.data = base + 32'(k);
      b.keep = (k == n - 1) ? lk : 4'hF;
      b.last = (k == n - 1);
      src_q[p].push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) src_q[i].delete();
    hold = '0;
    hs = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_src();
    exp_q.delete();
    tog_en = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tl_cyc.delete();
    fb_cyc.delete();
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats left after %0d cycles, want 0",
               exp_q.size(), maxc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_tready = 1'b1;
    push_pkt(0, 3, 32'hDEAD0000, 4'hF, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_tready !== '0 || m_tvalid !== 1'b0 || m_tdata !== '0 ||
          m_tkeep !== '0 || m_tlast !== 1'b0 || busy !== 1'b0 ||
          grant_idx !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b v=%b d=%h busy=%b g=%0d, want 0",
                 s_tready, m_tvalid, m_tdata, busy, grant_idx);
      end
    end
    clear_src();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (s_tready !== '0 || m_tvalid !== 1'b0 || m_tdata !== '0 ||
          m_tkeep !== '0 || m_tlast !== 1'b0 || busy !== 1'b0 ||
          grant_idx !== '0) begin
        errors++;
        $display("FAIL idle_after_reset: v=%b d=%h busy=%b g=%0d, want 0",
                 m_tvalid, m_tdata, busy, grant_idx);
      end
    end
  endtask

  task automatic test_single_pkt();
    int req;
    @(negedge clk);
    tl_cyc.delete();
    fb_cyc.delete();
    req = cyc + 1;
    push_pkt(0, 4, 32'h00000001, 4'h3, 1'b1);
    wait_drain(50);
    checks++;
    if (fb_cyc.size() != 1 || fb_cyc[0] - req != 1) begin
      errors++;
      $display("FAIL first_beat_latency: pkts=%0d lat=%0d, want 1/1",
               fb_cyc.size(), fb_cyc.size() > 0 ? fb_cyc[0] - req : -1);
    end
    // Pointer moved to port 1: it must beat port 0 on a tie.
    @(negedge clk);
    push_pkt(1, 1, 32'h000000B1, 4'hF, 1'b1);
    push_pkt(0, 1, 32'h000000A0, 4'hF, 1'b1);
    wait_drain(50);
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    push_pkt(0, 3, 32'h00000100, 4'hF, 1'b1);
    push_pkt(1, 3, 32'h00000200, 4'hF, 1'b1);
    push_pkt(0, 3, 32'h00000110, 4'hF, 1'b1);
    push_pkt(1, 3, 32'h00000210, 4'hF, 1'b1);
    wait_drain(100);
    checks++;
    if (tl_cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_pkts: got %0d packets, want 4", tl_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (tl_cyc[i] - tl_cyc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_spacing: gap %0d cycles, want 4",
                   tl_cyc[i] - tl_cyc[i-1]);
        end
      end
    end
`ifdef AXIS_PKT_ARBITER_PKTCNT_EN
    checks++;
    if (pkt_count[0 +: 32] !== 32'd2 || pkt_count[32 +: 32] !== 32'd2 ||
        pkt_count[64 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL pkt_count: got %0d/%0d/%0d, want 2/2/0",
               pkt_count[0 +: 32], pkt_count[32 +: 32], pkt_count[64 +: 32]);
    end
`endif
  endtask

  task automatic test_stall();
    @(negedge clk);
    tl_cyc.delete();
    push_pkt(1, 5, 32'h00000300, 4'h1, 1'b1);
    tog_en = 1'b1;
    wait_drain(100);
    tog_en = 1'b0;
    m_tready = 1'b1;
    checks++;
    if (tl_cyc.size() != 1) begin
      errors++;
      $display("FAIL stall_pkts: got %0d packets, want 1", tl_cyc.size());
    end
  endtask

  task automatic test_gaps();
    int n = 0;
    @(negedge clk);
    push_pkt(1, 4, 32'h00000400, 4'hF, 1'b1);
    while (!(busy && grant_idx == 1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL gap_grant_timeout: grant=%0d busy=%b, want 1/1",
               grant_idx, busy);
    end
    push_pkt(0, 2, 32'h00000500, 4'hF, 1'b1);
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      hold[1] = (k % 3 == 1);
      if (exp_q.size() > 0 && exp_q[0].port == 2'd1) begin
        checks++;
        if (!busy || grant_idx !== 1) begin
          errors++;
          $display("FAIL gap_hold: busy=%b grant=%0d, want 1/1",
                   busy, grant_idx);
        end
      end
    end
    hold = '0;
    wait_drain(50);
  endtask

  task automatic test_three_simul();
    int req;
    do_reset();
    @(negedge clk);
    req = cyc + 1;
    push_pkt(0, 1, 32'h00000600, 4'hF, 1'b1);
    push_pkt(1, 1, 32'h00000601, 4'h7, 1'b1);
    push_pkt(2, 1, 32'h00000602, 4'h1, 1'b1);
    wait_drain(50);
    checks++;
    if (tl_cyc.size() != 3 || tl_cyc[2] - req != 5 ||
        tl_cyc[1] - tl_cyc[0] != 2 || tl_cyc[2] - tl_cyc[1] != 2) begin
      errors++;
      $display("FAIL three_timing: pkts=%0d span=%0d, want 3/5",
               tl_cyc.size(), tl_cyc.size() == 3 ? tl_cyc[2] - req : -1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    m_tready = 1'b0;
    push_pkt(2, 4, 32'h00000700, 4'hF, 1'b0);
    while (!(busy && m_tvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20 || grant_idx !== 2) begin
      errors++;
      $display("FAIL mid_grant: grant=%0d busy=%b, want 2/1",
               grant_idx, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== '0 || busy !== 1'b0 ||
        grant_idx !== '0 || m_tdata !== '0) begin
      errors++;
      $display("FAIL reset_mid: v=%b rdy=%b busy=%b g=%0d d=%h, want 0",
               m_tvalid, s_tready, busy, grant_idx, m_tdata);
    end
    clear_src();
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b v=%b, want 0/0",
               busy, m_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_stall();
    test_gaps();
    test_three_simul();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d beats never seen, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges C_NUM_SLAVES AXI4-Stream packet sources (e.g. several net2axis instances) onto one AXI4-Stream master.
- A grant is held from the first beat to the TLAST beat of one packet, so packets never interleave.
- Sits between the traffic generators and the DUT stream input in simulation and in the FPGA datapath.

Parameters:
- C_TDATA_WIDTH, 32, data width in bits; multiple of 8.
- C_NUM_SLAVES, 2, number of slave ports; legal range 2..8.
- C_IDX_WIDTH, 3, width of GRANT_IDX; must satisfy 2**C_IDX_WIDTH >= C_NUM_SLAVES.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TVALID  in  C_NUM_SLAVES  per-port valid.
- S_AXIS_TDATA  in  C_NUM_SLAVES*C_TDATA_WIDTH  per-port data; port i occupies slice [i*W +: W].
- S_AXIS_TKEEP  in  C_NUM_SLAVES*C_TDATA_WIDTH/8  per-port byte keep, packed the same way.
- S_AXIS_TLAST  in  C_NUM_SLAVES  per-port last.
- S_AXIS_TREADY  out  C_NUM_SLAVES  per-port ready.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TDATA  out  C_TDATA_WIDTH  master data.
- M_AXIS_TKEEP  out  C_TDATA_WIDTH/8  master keep.
- M_AXIS_TLAST  out  1  master last.
- M_AXIS_TREADY  in  1  master ready.
- GRANT_IDX  out  C_IDX_WIDTH  index of the granted port; valid while BUSY=1.
- BUSY  out  1  high while a packet is locked.

Behaviour:
- Reset is asynchronous and active-low. While ARESETN=0:
  - state=IDLE, BUSY=0, GRANT_IDX=0, round-robin pointer=0.
  - S_AXIS_TREADY all 0; M_AXIS_TVALID, TDATA, TKEEP, TLAST all 0.
  - Deassertion takes effect at the next ACLK edge.
- FSM has two states: IDLE and XFER.
- IDLE:
  - Master and slave outputs are driven 0.
  - Search starts at port ptr and wraps modulo C_NUM_SLAVES; the first port with S_AXIS_TVALID=1 wins.
  - On the edge where a winner exists: GRANT_IDX<=winner, BUSY<=1, state<=XFER.
  - If no port has TVALID, remain in IDLE.
  - Arbitration costs exactly 1 cycle: first beat appears on M_AXIS the cycle after the winner's TVALID is seen in IDLE.
- XFER is a combinational pass-through from granted port g; zero added latency:
  - M_AXIS_TVALID = S_AXIS_TVALID[g]; TDATA, TKEEP, TLAST taken from slice g.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other TREADY bits are 0.
  - A beat transfers when M_AXIS_TVALID && M_AXIS_TREADY.
  - On a transfer with TLAST=1: ptr<=(g+1) mod C_NUM_SLAVES, BUSY<=0, state<=IDLE.
- Boundary and fairness rules:
  - Back-to-back packets cost 1 idle cycle between them.
  - If the granted port is the only requester, it wins again after that idle cycle.
  - The granted source dropping TVALID mid-packet holds the grant; there is no timeout.
  - M_AXIS_TREADY=0 stalls indefinitely; AXIS rules hold: TDATA, TKEEP, TLAST stable while TVALID && !TREADY, since sources obey AXIS.
  - A single-beat packet (TLAST on the first beat) completes XFER in 1 cycle.
  - Multiple simultaneous TVALIDs are resolved by the pointer only; no fixed priority.
  - Inputs of non-granted ports are ignored; their TVALID may toggle freely.
  - Reset asserted mid-packet aborts the packet immediately. No partial-packet recovery; the source is expected to also be reset.

Optional Feature:
- Macro: AXIS_PKT_ARBITER_PKTCNT_EN.
- When defined:
  - Adds output PKT_COUNT [C_NUM_SLAVES*32-1:0].
  - One 32-bit counter per port, incremented on each TLAST transfer from that port; wraps 0xFFFFFFFF->0.
  - Counters reset to 0 on ARESETN.
- When undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, 2 ports idle, M_AXIS_TREADY=1 -> all outputs 0, BUSY=0, GRANT_IDX=0 for 20 cycles; assert ARESETN mid-XFER -> outputs 0 in the same cycle, before the next edge.
- Port0 only, 4-beat packet 0x00000001..0x00000004, TKEEP=0xF, last TKEEP=0x3 -> M_AXIS shows 4 identical beats starting 1 cycle after TVALID; BUSY falls after the TLAST beat; ptr=1.
- Ports 0 and 1 both continuously sending 3-beat packets -> grant order 0,1,0,1; no interleaving; 1 idle cycle between packets; with PKTCNT_EN, counts 2/2 after 4 packets.
- M_AXIS_TREADY toggling 1010... during a 5-beat packet from port1 -> all 5 beats delivered in order exactly once; S_AXIS_TREADY[1] mirrors M_AXIS_TREADY; S_AXIS_TREADY[0]=0 throughout.
- Port1 TVALID gaps mid-packet while port0 requests -> grant stays 1 until port1's TLAST; port0 is served next.
- Single-beat packets from 3 ports (C_NUM_SLAVES=3) arriving simultaneously -> order 0,1,2, each a 1-cycle XFER; 6 total cycles from first request.
